// File: rtl/exe_issue_ctrl_pkg.sv
// Shared types and sizes for the execution issue controller.
// Operand width comes from DATA_WIDTH (defaults to 32).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package exe_issue_ctrl_pkg;

  localparam int RADDR_W      = 5;
  localparam int ISSUE_QDEPTH = 4;
  localparam int EXE_LATENCY  = 2;

  localparam int ITYPE_W = 7;
  localparam int F3_W    = 3;
  localparam int F7_W    = 7;
  localparam int IMM_W   = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HAZ   = 2'd2,
    ST_STALL = 2'd3
  } ctrl_state_e;

  function automatic ctrl_state_e classify(
    input logic empty,
    input logic stall,
    input logic haz
  );
    ctrl_state_e st;
    st = ST_RUN;
    priority case (1'b1)
      empty:   st = ST_IDLE;
      stall:   st = ST_STALL;
      haz:     st = ST_HAZ;
      default: st = ST_RUN;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/exe_uop_fifo.sv
// Small circular uop queue with push, pop and flush.
// DEPTH must be a power of two; pointers wrap naturally.
module exe_uop_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign rdata_o = mem_q[rd_ptr_q];

  // entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= wr_ptr_q;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/exe_issue_ctrl.sv
// Issue controller: uop queue, in-flight rd tracker, RAW check.
// Define EXE_ISSUE_PERF_EN to build the perf counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module exe_issue_ctrl
  import exe_issue_ctrl_pkg::*;
#(
  parameter int QDEPTH      = ISSUE_QDEPTH,
  parameter int EXE_LATENCY = exe_issue_ctrl_pkg::EXE_LATENCY,
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int RADDR_W     = exe_issue_ctrl_pkg::RADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ITYPE_W-1:0]    in_instruction_type,
  input  logic [F3_W-1:0]       in_funct3,
  input  logic [F7_W-1:0]       in_funct7,
  input  logic [IMM_W-1:0]      in_immediate,
  input  logic [RADDR_W-1:0]    in_rs1,
  input  logic [RADDR_W-1:0]    in_rs2,
  input  logic [RADDR_W-1:0]    in_rd,
  input  logic                  in_rd_we,
  input  logic                  flush,
  input  logic                  system_stall,
  output logic [RADDR_W-1:0]    rf_rs1_addr,
  output logic [RADDR_W-1:0]    rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data,
  output logic                  uop_valid,
  output logic [ITYPE_W-1:0]    instruction_type,
  output logic [F3_W-1:0]       funct3,
  output logic [F7_W-1:0]       funct7,
  output logic [IMM_W-1:0]      immediate,
  output logic [DATA_WIDTH-1:0] data_src1,
  output logic [DATA_WIDTH-1:0] data_src2,
  output logic [1:0]            ctrl_state,
  output logic [31:0]           perf_issue_cnt,
  output logic [31:0]           perf_hazard_cnt,
  output logic [31:0]           perf_stall_cnt
);

  typedef struct packed {
    logic [ITYPE_W-1:0] itype;
    logic [F3_W-1:0]    f3;
    logic [F7_W-1:0]    f7;
    logic [IMM_W-1:0]   imm;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic               rd_we;
  } uop_t;

  typedef struct packed {
    logic               v;
    logic [RADDR_W-1:0] rd;
  } trk_t;

  uop_t        wr_uop, hd;
  logic        push, full, empty;
  logic        hit, hazard, issue;
  trk_t        trk_d;
  trk_t        trk_q [1:EXE_LATENCY];
  ctrl_state_e st;

  assign wr_uop = '{
    itype: in_instruction_type,
    f3:    in_funct3,
    f7:    in_funct7,
    imm:   in_immediate,
    rs1:   in_rs1,
    rs2:   in_rs2,
    rd:    in_rd,
    rd_we: in_rd_we
  };

  assign in_ready = ~full;
  assign push     = in_valid & in_ready & ~flush;

  exe_uop_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(uop_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (issue),
    .flush_i (flush),
    .wdata_i (wr_uop),
    .rdata_o (hd),
    .full_o  (full),
    .empty_o (empty)
  );

  // RAW check against slots still ahead of writeback
  always_comb begin
    hit = 1'b0;
    for (int k = 1; k < EXE_LATENCY; k++) begin
      if (trk_q[k].v && hd.rs1 != '0 && hd.rs1 == trk_q[k].rd)
        hit = 1'b1;
      if (trk_q[k].v && hd.rs2 != '0 && hd.rs2 == trk_q[k].rd)
        hit = 1'b1;
    end
  end

  assign hazard = hit & ~empty;
  assign issue  = ~empty & ~hazard & ~system_stall & ~flush;

  assign trk_d = '{
    v:  issue & hd.rd_we & (hd.rd != '0),
    rd: hd.rd
  };

  // shift in-flight rd record alongside the execution pipe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= EXE_LATENCY; k++)
        trk_q[k] <= '0;
    end else begin
      trk_q[1] <= trk_d;
      for (int k = 2; k <= EXE_LATENCY; k++)
        trk_q[k] <= trk_q[k-1];
    end
  end

  // classify the current cycle for debug and perf
  always_comb begin
    st = ST_IDLE;
    st = classify(empty, system_stall, hazard);
  end

  assign ctrl_state = st;

  assign rf_rs1_addr      = hd.rs1;
  assign rf_rs2_addr      = hd.rs2;
  assign uop_valid        = issue;
  assign instruction_type = hd.itype;
  assign funct3           = hd.f3;
  assign funct7           = hd.f7;
  assign immediate        = hd.imm;
  assign data_src1        = rf_rs1_data;
  assign data_src2        = rf_rs2_data;

`ifdef EXE_ISSUE_PERF_EN
  logic [31:0] iss_cnt_q, haz_cnt_q, stl_cnt_q;

  // free-running event counters, wrap at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_cnt_q <= '0;
      haz_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      if (issue)
        iss_cnt_q <= iss_cnt_q + 32'd1;
      if (st == ST_HAZ)
        haz_cnt_q <= haz_cnt_q + 32'd1;
      if (st == ST_STALL)
        stl_cnt_q <= stl_cnt_q + 32'd1;
    end
  end

  assign perf_issue_cnt  = iss_cnt_q;
  assign perf_hazard_cnt = haz_cnt_q;
  assign perf_stall_cnt  = stl_cnt_q;
`else
  assign perf_issue_cnt  = '0;
  assign perf_hazard_cnt = '0;
  assign perf_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Directed bench for exe_issue_ctrl.
// Inputs change on the falling edge; outputs checked 1ns later.
module tb_exe_issue_ctrl;

`ifdef EXE_ISSUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_instruction_type;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [20:0] in_immediate;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we;
  logic        flush;
  logic        system_stall;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        uop_valid;
  logic [6:0]  instruction_type;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [20:0] immediate;
  logic [31:0] data_src1, data_src2;
  logic [1:0]  ctrl_state;
  logic [31:0] perf_issue_cnt, perf_hazard_cnt, perf_stall_cnt;

  logic [31:0] regs [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rf_rs1_data = regs[rf_rs1_addr];
  assign rf_rs2_data = regs[rf_rs2_addr];

  exe_issue_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_instruction_type (in_instruction_type),
    .in_funct3           (in_funct3),
    .in_funct7           (in_funct7),
    .in_immediate        (in_immediate),
    .in_rs1              (in_rs1),
    .in_rs2              (in_rs2),
    .in_rd               (in_rd),
    .in_rd_we            (in_rd_we),
    .flush               (flush),
    .system_stall        (system_stall),
    .rf_rs1_addr         (rf_rs1_addr),
    .rf_rs2_addr         (rf_rs2_addr),
    .rf_rs1_data         (rf_rs1_data),
    .rf_rs2_data         (rf_rs2_data),
    .uop_valid           (uop_valid),
    .instruction_type    (instruction_type),
    .funct3              (funct3),
    .funct7              (funct7),
    .immediate           (immediate),
    .data_src1           (data_src1),
    .data_src2           (data_src2),
    .ctrl_state          (ctrl_state),
    .perf_issue_cnt      (perf_issue_cnt),
    .perf_hazard_cnt     (perf_hazard_cnt),
    .perf_stall_cnt      (perf_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [20:0] id,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic we);
    in_valid            = v;
    in_immediate        = id;
    in_rs1              = rs1;
    in_rs2              = rs2;
    in_rd               = rd;
    in_rd_we            = we;
    in_instruction_type = 7'h33;
    in_funct3           = id[2:0];
    in_funct7           = 7'h00;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero_state(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_valid"}, 32'(uop_valid), 32'd0);
    chk({tag, "_state"}, 32'(ctrl_state), 32'd0);
    chk({tag, "_piss"}, perf_issue_cnt, 32'd0);
    chk({tag, "_phaz"}, perf_hazard_cnt, 32'd0);
    chk({tag, "_pstl"}, perf_stall_cnt, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++)
      regs[i] = 32'hA000_0000 + 32'(i);
    reset        = 1'b0;
    flush        = 1'b0;
    system_stall = 1'b0;
    drv(1'b0, 21'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk_zero_state("reset");
    tick;

    // four independent uops back to back
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 21'(i), 5'd0, 5'd0, 5'(i), 1'b1);
      #1 chk("t1_valid", 32'(uop_valid), 32'(i > 1));
      chk("t1_state", 32'(ctrl_state), (i > 1) ? 32'd1 : 32'd0);
      if (i > 1) chk("t1_imm", 32'(immediate), 32'(i - 1));
      tick;
    end
    drv(1'b0, 21'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1 chk("t1_imm4", 32'(immediate), 32'd4);
    chk("t1_valid4", 32'(uop_valid), 32'd1);
    tick;
    #1 chk("t1_drain", 32'(uop_valid), 32'd0);
    chk("t1_idle", 32'(ctrl_state), 32'd0);
    tick;

    // fill under stall, fifth entry held until a pop
    system_stall = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      drv(1'b1, 21'(i), 5'd0, 5'd0, 5'(i), 1'b1);
      #1 chk("full_noiss", 32'(uop_valid), 32'd0);
      tick;
    end
    drv(1'b1, 21'd9, 5'd0, 5'd0, 5'd9, 1'b1);
    #1 chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_state", 32'(ctrl_state), 32'd3);
    tick;
    system_stall = 1'b0;
    #1 chk("full_popready", 32'(in_ready), 32'd0);
    chk("full_pop_v", 32'(uop_valid), 32'd1);
    chk("full_pop_imm", 32'(immediate), 32'd5);
    tick;
    #1 chk("full_reopen", 32'(in_ready), 32'd1);
    chk("full_imm6", 32'(immediate), 32'd6);
    tick;
    drv(1'b0, 21'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1 chk("full_imm7", 32'(immediate), 32'd7);
    tick;
    #1 chk("full_imm8", 32'(immediate), 32'd8);
    tick;
    #1 chk("full_imm9", 32'(immediate), 32'd9);
    chk("full_v9", 32'(uop_valid), 32'd1);
    tick;
    #1 chk("full_empty", 32'(uop_valid), 32'd0);
    tick;

    // RAW: add x5 then add x6,x5,x1
    drv(1'b1, 21'd10, 5'd1, 5'd2, 5'd5, 1'b1);
    #1 chk("t2_c-1", 32'(uop_valid), 32'd0);
    tick;
    drv(1'b1, 21'd11, 5'd5, 5'd1, 5'd6, 1'b1);
    #1 chk("t2_c0_v", 32'(uop_valid), 32'd1);
    chk("t2_c0_imm", 32'(immediate), 32'd10);
    tick;
    drv(1'b0, 21'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1 chk("t2_c1_bubble", 32'(uop_valid), 32'd0);
    chk("t2_c1_haz", 32'(ctrl_state), 32'd2);
    tick;
    regs[5] = 32'h0000_5555;
    #1 chk("t2_c2_v", 32'(uop_valid), 32'd1);
    chk("t2_c2_imm", 32'(immediate), 32'd11);
    chk("t2_c2_addr", 32'(rf_rs1_addr), 32'd5);
    chk("t2_c2_src1", data_src1, 32'h0000_5555);
    chk("t2_c2_src2", data_src2, 32'hA000_0001);
    tick;
    tick;

    // x0 never creates a dependency
    drv(1'b1, 21'd12, 5'd0, 5'd0, 5'd0, 1'b1);
    #1 chk("t3_pre", 32'(uop_valid), 32'd0);
    tick;
    drv(1'b1, 21'd13, 5'd0, 5'd0, 5'd7, 1'b1);
    #1 chk("t3_a", 32'(immediate), 32'd12);
    chk("t3_a_v", 32'(uop_valid), 32'd1);
    tick;
    drv(1'b0, 21'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1 chk("t3_b_v", 32'(uop_valid), 32'd1);
    chk("t3_b_imm", 32'(immediate), 32'd13);
    chk("t3_b_run", 32'(ctrl_state), 32'd1);
    tick;
    tick;

    // flush with 3 queued, a push offered and a head ready
    system_stall = 1'b1;
    for (int i = 14; i <= 16; i++) begin
      drv(1'b1, 21'(i), 5'd0, 5'd0, 5'd8, 1'b1);
      tick;
    end
    system_stall = 1'b0;
    drv(1'b1, 21'd17, 5'd0, 5'd0, 5'd9, 1'b1);
    #1 chk("t5_inflight", 32'(immediate), 32'd14);
    tick;
    flush = 1'b1;
    drv(1'b1, 21'd18, 5'd0, 5'd0, 5'd10, 1'b1);
    #1 chk("t5_noissue", 32'(uop_valid), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    tick;
    flush = 1'b0;
    drv(1'b1, 21'd19, 5'd0, 5'd0, 5'd3, 1'b1);
    #1 chk("t5_empty_v", 32'(uop_valid), 32'd0);
    chk("t5_empty_st", 32'(ctrl_state), 32'd0);
    tick;
    drv(1'b0, 21'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1 chk("t5_after_imm", 32'(immediate), 32'd19);
    chk("t5_after_v", 32'(uop_valid), 32'd1);
    tick;
    #1 chk("t5_nopush", 32'(uop_valid), 32'd0);
    tick;

    // asynchronous reset with a full queue
    system_stall = 1'b1;
    for (int i = 20; i <= 23; i++) begin
      drv(1'b1, 21'(i), 5'd0, 5'd0, 5'd4, 1'b1);
      tick;
    end
    drv(1'b0, 21'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1 chk("t6_full", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1 chk_zero_state("t6_rst");
    tick;
    reset        = 1'b1;
    system_stall = 1'b0;
    #1 chk("t6_after_v", 32'(uop_valid), 32'd0);
    chk("t6_after_st", 32'(ctrl_state), 32'd0);
    tick;

    // stall three cycles with two queued
    system_stall = 1'b1;
    drv(1'b1, 21'd24, 5'd0, 5'd0, 5'd10, 1'b1);
    #1 chk("t4_q0", 32'(ctrl_state), 32'd0);
    tick;
    drv(1'b1, 21'd25, 5'd0, 5'd0, 5'd11, 1'b1);
    #1 chk("t4_s1_v", 32'(uop_valid), 32'd0);
    chk("t4_s1_st", 32'(ctrl_state), 32'd3);
    tick;
    drv(1'b0, 21'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1 chk("t4_s2_v", 32'(uop_valid), 32'd0);
    chk("t4_s2_st", 32'(ctrl_state), 32'd3);
    tick;
    #1 chk("t4_s3_v", 32'(uop_valid), 32'd0);
    chk("t4_s3_st", 32'(ctrl_state), 32'd3);
    tick;
    system_stall = 1'b0;
    #1 chk("t4_r1_v", 32'(uop_valid), 32'd1);
    chk("t4_r1_imm", 32'(immediate), 32'd24);
    chk("t4_r1_st", 32'(ctrl_state), 32'd1);
    tick;
    #1 chk("t4_r2_imm", 32'(immediate), 32'd25);
    chk("t4_r2_v", 32'(uop_valid), 32'd1);
    tick;
    #1 chk("t4_end_v", 32'(uop_valid), 32'd0);
    chk("t4_pstall", perf_stall_cnt, PERF ? 32'd3 : 32'd0);
    chk("t4_pissue", perf_issue_cnt, PERF ? 32'd2 : 32'd0);
    chk("t4_phaz", perf_hazard_cnt, 32'd0);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
